// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low row at a time, debounces
// press and release on scan ticks, and emits one pulse per accepted key with
// its hex code. Accepted codes are shifted into a 16-bit display register.
module keypad_scanner #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  rows,
  input  logic [3:0]  cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] dataout
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

  state_t              state, state_nxt;
  logic [SCAN_DIV-1:0] div;
  logic                tick;
  logic [3:0]          cols_m, cols_s;
  logic [3:0]          count, count_nxt;
  logic [3:0]          rows_nxt;
  logic [1:0]          row_idx, col_idx, row_idx_nxt, col_idx_nxt;
  logic                one_low, accept;
  logic [3:0]          code;

  // Index of the single low bit in a one-hot-low nibble.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      default: low_idx = 2'd3;
    endcase
  endfunction

  // Keypad legend, row-major.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  assign tick    = &div;
  assign one_low = (cols_s == 4'b1110) || (cols_s == 4'b1101) ||
                   (cols_s == 4'b1011) || (cols_s == 4'b0111);
  // Uses the next-cycle indices so a single-scan debounce can emit on the
  // detection tick itself.
  assign code    = key_map(row_idx_nxt, col_idx_nxt);

  // Free-running tick divider and two-flop column synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      cols_m <= 4'hF;
      cols_s <= 4'hF;
    end else begin
      div    <= div + {{(SCAN_DIV-1){1'b0}}, 1'b1};
      cols_m <= cols;
      cols_s <= cols_m;
    end
  end

  // FSM state, counters, row drive and latched key position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      count   <= '0;
      rows    <= 4'b1110;
      row_idx <= '0;
      col_idx <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      rows    <= rows_nxt;
      row_idx <= row_idx_nxt;
      col_idx <= col_idx_nxt;
    end
  end

  // Next-state: everything moves only on a scan tick; rows freeze outside SCAN.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    rows_nxt    = rows;
    row_idx_nxt = row_idx;
    col_idx_nxt = col_idx;
    accept      = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            row_idx_nxt = low_idx(rows);
            col_idx_nxt = low_idx(cols_s);
            if (DB == 4'd1) begin
              accept    = 1'b1;
              state_nxt = HELD;
              count_nxt = '0;
            end else begin
              state_nxt = DEBOUNCE;
              count_nxt = 4'd1;
            end
          end else begin
            rows_nxt  = {rows[2:0], rows[3]};
            count_nxt = '0;
          end
        end
        DEBOUNCE: begin
          if (cols_s == ~(4'b0001 << col_idx)) begin
            if (count + 4'd1 == DB) begin
              accept    = 1'b1;
              state_nxt = HELD;
              count_nxt = '0;
            end else begin
              count_nxt = count + 4'd1;
            end
          end else begin
            state_nxt = SCAN;
            count_nxt = '0;
          end
        end
        HELD: begin
          if (cols_s == 4'hF) begin
            if (count + 4'd1 == DB) begin
              state_nxt = SCAN;
              count_nxt = '0;
            end else begin
              count_nxt = count + 4'd1;
            end
          end else begin
            count_nxt = '0;
          end
        end
        default: begin
          state_nxt = SCAN;
          count_nxt = '0;
        end
      endcase
    end
  end

  // Output registers: code and display shift only with an accepted key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      dataout   <= '0;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= code;
        dataout  <= {dataout[11:0], code};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a fast scan (tick every 4 cycles) and a
// matrix model that pulls a column low only while its row is driven.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] dataout;

  keypad_scanner #(.SCAN_DIV(2), .DEBOUNCE_SCANS(4)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .cols(cols),
    .key_valid(key_valid), .key_code(key_code), .dataout(dataout)
  );

  always #5 clk = ~clk;

  // Pressed-key matrix, [row][col].
  logic [3:0][3:0] keys = '0;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !rows[r]) cols[c] = 1'b0;
  end

  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'hE, 4'h0, 4'hF, 4'hD};

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int run      = 0;
  int max_run  = 0;
  logic [15:0] exp_data = '0;

  // Pulse monitor: counts pulses and tracks the widest one.
  always @(negedge clk) begin
    if (key_valid) begin
      if (run == 0) pulses++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  function automatic logic [3:0] kcode(input int r, input int c);
    logic [3:0] t [16];
    t = KMAP;
    return t[r*4 + c];
  endfunction

  task automatic press(input int r, input int c);
    keys[r][c] = 1'b1;
  endtask

  task automatic release_all();
    keys = '0;
  endtask

  // Waits for the edge where rows starts driving row r (bounded).
  task automatic wait_row(input int r);
    logic [3:0] want, prev;
    bit hit;
    want = ~(4'b0001 << r);
    prev = rows;
    hit  = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      if (rows == want && prev != want) hit = 1;
      prev = rows;
    end
    n_checks++;
    if (!hit) begin n_fail++; $display("FAIL wait_row%0d: row never entered, rows=%b", r, rows); end
  endtask

  task automatic test_reset();
    logic [3:0] seq [4];
    seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rows !== 4'b1110) begin n_fail++; $display("FAIL reset_rows: got %b want 1110", rows); end
    n_checks++; if (dataout !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", dataout); end
    n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", key_code); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (rows !== seq[i]) begin n_fail++; $display("FAIL idle_rot%0d: got %b want %b", i, rows, seq[i]); end
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL idle_pulses: got %0d want 0", pulses); end
    n_checks++; if (dataout !== 16'h0) begin n_fail++; $display("FAIL idle_data: got %h want 0000", dataout); end
  endtask

  task automatic test_single_key();
    int p0, changes;
    logic [3:0] prev;
    p0 = pulses;
    max_run = 0;
    press(1, 2);
    repeat (100) @(posedge clk);
    #1;
    n_checks++; if (rows !== 4'b1101) begin n_fail++; $display("FAIL held_rows: got %b want 1101", rows); end
    repeat (100) @(posedge clk);
    #1;
    exp_data = {exp_data[11:0], kcode(1, 2)};
    n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses - p0); end
    n_checks++; if (max_run !== 1) begin n_fail++; $display("FAIL single_width: got %0d want 1", max_run); end
    n_checks++; if (key_code !== 4'h6) begin n_fail++; $display("FAIL single_code: got %h want 6", key_code); end
    n_checks++; if (dataout !== exp_data) begin n_fail++; $display("FAIL single_data: got %h want %h", dataout, exp_data); end
    release_all();
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (rows !== 4'b1101) begin n_fail++; $display("FAIL release_frozen: got %b want 1101", rows); end
    repeat (30) @(posedge clk);
    #1;
    changes = 0;
    prev = rows;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (rows != prev) changes++;
      prev = rows;
    end
    n_checks++; if (changes !== 4) begin n_fail++; $display("FAIL release_rotate: got %0d changes want 4", changes); end
  endtask

  task automatic test_sequence();
    int p0;
    int rs [5];
    int cs [5];
    rs = '{0, 0, 0, 0, 1};
    cs = '{0, 1, 2, 3, 1};
    p0 = pulses;
    for (int k = 0; k < 5; k++) begin
      press(rs[k], cs[k]);
      repeat (80) @(posedge clk);
      release_all();
      repeat (80) @(posedge clk);
      #1;
      exp_data = {exp_data[11:0], kcode(rs[k], cs[k])};
      if (k == 3) begin
        n_checks++; if (dataout !== 16'h123A) begin n_fail++; $display("FAIL seq_123A: got %h want 123A", dataout); end
        n_checks++; if (pulses - p0 !== 4) begin n_fail++; $display("FAIL seq_pulses: got %0d want 4", pulses - p0); end
      end
    end
    n_checks++; if (dataout !== 16'h23A5) begin n_fail++; $display("FAIL seq_23A5: got %h want 23A5", dataout); end
    n_checks++; if (dataout !== exp_data) begin n_fail++; $display("FAIL seq_model: got %h want %h", dataout, exp_data); end
  endtask

  task automatic test_bounce();
    int p0, changes;
    logic [3:0] prev;
    p0 = pulses;
    wait_row(2);
    press(2, 0);
    repeat (8) @(posedge clk);
    release_all();
    repeat (12) @(posedge clk);
    #1;
    changes = 0;
    prev = rows;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (rows != prev) changes++;
      prev = rows;
    end
    n_checks++; if (pulses !== p0) begin n_fail++; $display("FAIL bounce_pulse: got %0d want %0d", pulses, p0); end
    n_checks++; if (dataout !== exp_data) begin n_fail++; $display("FAIL bounce_data: got %h want %h", dataout, exp_data); end
    n_checks++; if (changes !== 4) begin n_fail++; $display("FAIL bounce_rotate: got %0d changes want 4", changes); end
  endtask

  task automatic test_multi_and_release_bounce();
    int p0, changes;
    logic [3:0] prev;
    p0 = pulses;
    press(0, 0);
    press(0, 1);
    changes = 0;
    prev = rows;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rows != prev) changes++;
      prev = rows;
    end
    release_all();
    n_checks++; if (pulses !== p0) begin n_fail++; $display("FAIL multi_pulse: got %0d want %0d", pulses, p0); end
    n_checks++; if (changes < 24) begin n_fail++; $display("FAIL multi_rotate: got %0d changes want >=24", changes); end
    repeat (40) @(posedge clk);
    press(2, 2);
    repeat (60) @(posedge clk);
    release_all();
    repeat (8) @(posedge clk);
    press(2, 2);
    repeat (40) @(posedge clk);
    release_all();
    repeat (60) @(posedge clk);
    #1;
    exp_data = {exp_data[11:0], kcode(2, 2)};
    n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL relbounce_pulses: got %0d want 1", pulses - p0); end
    n_checks++; if (dataout !== exp_data) begin n_fail++; $display("FAIL relbounce_data: got %h want %h", dataout, exp_data); end
  endtask

  task automatic test_reset_mid();
    int p0;
    // Reset while debouncing key A (second debounce tick reached).
    p0 = pulses;
    wait_row(0);
    press(0, 3);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_data = '0;
    n_checks++; if (rows !== 4'b1110 || dataout !== 16'h0 || key_code !== 4'h0 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_debounce: rows=%b data=%h code=%h kv=%b want 1110/0000/0/0", rows, dataout, key_code, key_valid);
    end
    n_checks++; if (pulses !== p0) begin n_fail++; $display("FAIL rst_debounce_pulse: got %0d want %0d", pulses, p0); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (60) @(posedge clk);
    release_all();
    repeat (60) @(posedge clk);
    press(0, 0);
    repeat (60) @(posedge clk);
    #1;
    exp_data = 16'h00A1;
    n_checks++; if (dataout !== exp_data) begin n_fail++; $display("FAIL pre_held_data: got %h want 00A1", dataout); end
    // Reset while held.
    rst_n = 1'b0;
    #1;
    exp_data = '0;
    n_checks++; if (rows !== 4'b1110 || dataout !== 16'h0 || key_code !== 4'h0 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_held: rows=%b data=%h code=%h kv=%b want 1110/0000/0/0", rows, dataout, key_code, key_valid);
    end
    p0 = pulses;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (pulses !== p0) begin n_fail++; $display("FAIL rst_early_pulse: got %0d want %0d", pulses, p0); end
    repeat (60) @(posedge clk);
    #1;
    exp_data = {exp_data[11:0], kcode(0, 0)};
    n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL rst_redebounce: got %0d want 1", pulses - p0); end
    n_checks++; if (dataout !== exp_data) begin n_fail++; $display("FAIL rst_redata: got %h want %h", dataout, exp_data); end
    release_all();
    repeat (60) @(posedge clk);
  endtask

  task automatic test_random();
    int p0, r, c, hold, gap;
    p0 = pulses;
    for (int k = 0; k < 12; k++) begin
      r    = int'($urandom_range(0, 3));
      c    = int'($urandom_range(0, 3));
      hold = int'($urandom_range(60, 120));
      gap  = int'($urandom_range(50, 100));
      press(r, c);
      repeat (hold) @(posedge clk);
      release_all();
      repeat (gap) @(posedge clk);
      #1;
      exp_data = {exp_data[11:0], kcode(r, c)};
      n_checks++;
      if (key_code !== kcode(r, c) || dataout !== exp_data) begin
        n_fail++; $display("FAIL rand%0d: code=%h data=%h want code=%h data=%h", k, key_code, dataout, kcode(r, c), exp_data);
      end
    end
    n_checks++; if (pulses - p0 !== 12) begin n_fail++; $display("FAIL rand_pulses: got %0d want 12", pulses - p0); end
    n_checks++; if (max_run !== 1) begin n_fail++; $display("FAIL rand_width: got %0d want 1", max_run); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_multi_and_release_bounce();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one row low at a time and reading the active-low column lines.
- Debounces presses and releases, and emits one pulse per debounced keypress with its 4-bit hex code.
- Shifts each new code into a 16-bit register. That register feeds the four-digit seven-segment display driver's 16-bit data input directly: newest digit in [3:0], oldest in [15:12].

Parameters:
- SCAN_DIV, 16: scan tick period is 2^SCAN_DIV clk cycles. Minimum 2.
- DEBOUNCE_SCANS, 4: consecutive stable ticks needed to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rows  output  4  row drives, one-hot active-low; rows[i]=0 drives row i
- cols  input  4  column sense, active-low, externally pulled up, asynchronous to clk
- key_valid  output  1  one-cycle pulse when a debounced press is accepted
- key_code  output  4  code of the last accepted key; held between presses
- dataout  output  16  last four accepted codes; newest in [3:0]

Behaviour:
- Reset (async, rst_n=0): rows=4'b1110, key_valid=0, key_code=0, dataout=0, state=SCAN, divider=0, debounce counter=0, column synchronizer=4'b1111.
- cols pass through a 2-flop synchronizer (cols_s). Only cols_s is used.
- Tick:
  - Free-running SCAN_DIV-bit divider.
  - tick = 1-cycle strobe when the divider is all ones.
  - All FSM actions below occur only on tick edges.
- Key map (row,col -> code):
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
- State SCAN:
  - On tick, if cols_s has exactly one bit low: latch row index and column index, set count=1, go to DEBOUNCE. rows stay frozen.
  - Otherwise (all high, or two or more low) rotate rows <= {rows[2:0],rows[3]}. Sequence is 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- State DEBOUNCE (rows frozen):
  - On tick, if cols_s still has exactly the latched column low and no other: count+1.
  - When count reaches DEBOUNCE_SCANS: on that tick edge register key_code=code, dataout={dataout[11:0],code}, key_valid=1 for exactly one cycle. Then go to HELD with count=0.
  - Any mismatch on a tick: go to SCAN. The rows rotation resumes from the frozen row on the next tick. No output change.
  - With DEBOUNCE_SCANS=1, acceptance happens on the detection tick itself.
- State HELD (rows frozen):
  - On tick, if cols_s==4'b1111: count+1. Otherwise count=0.
  - When count reaches DEBOUNCE_SCANS: go to SCAN with count=0.
  - No repeat pulses while held, regardless of duration.
  - Other keys pressed while HELD are ignored.
- key_valid is low at all other times.
- dataout and key_code change only together with a key_valid pulse.
- Sampling latency: cols_s at a tick reflects pins 2 cycles earlier, within the same row dwell. This is why SCAN_DIV>=2.
- Reset asserted mid-DEBOUNCE or mid-HELD: all outputs return to reset values immediately. A partially debounced key is not emitted.
- Counters never wrap: count saturates at DEBOUNCE_SCANS before the state change.

Test Plan:
Bench parameters: SCAN_DIV=2 (tick every 4 cycles), DEBOUNCE_SCANS=4. The keypad model pulls the col low only while its row is driven low.
1. Reset then idle 20 cycles -> rows=1110 during reset; afterwards rows steps 1101, 1011, 0111, 1110 every 4 cycles. key_valid never high, dataout=0x0000.
2. Hold key row1/col2 for 200 cycles -> exactly one key_valid pulse, 1 cycle wide. key_code=6, dataout=0x0006. rows frozen at 1101 until 4 release ticks after the key is dropped.
3. Press and release 1, 2, 3, A in turn, each held 80 cycles with 80 idle cycles between -> 4 pulses, dataout=0x123A. A fifth key 5 gives 0x23A5.
4. Bounce: row2/col0 low for 2 ticks, then released -> no key_valid, dataout unchanged, rows resumes rotating.
5. Two columns low in row0 simultaneously -> no pulse, rows keeps rotating. Release bounce on a held key (high 2 ticks, low again, then high 4 ticks) -> still only one pulse total.
6. Assert rst_n=0 in DEBOUNCE (count=2) and separately in HELD with dataout=0x00A1 -> immediately rows=1110, dataout=0, key_code=0, key_valid=0. No pulse after release of reset while the key is still held until a full new debounce completes.
